// File: rtl/integrate_dump_pkg.sv
// integrate_dump_pkg: shared sdr_lib constants for the integrate-and-dump decimator
package integrate_dump_pkg;
  localparam int WIDTH_IN_DEF = 16;
  localparam int LOG2_MAX_DEF = 8;
endpackage

// File: rtl/integrate_dump.sv
// integrate_dump: sums rate signed samples per period and dumps the full-precision total
module integrate_dump
  import integrate_dump_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  parameter int LOG2_MAX = LOG2_MAX_DEF,
  localparam int WIDTH_OUT = WIDTH_IN + LOG2_MAX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [LOG2_MAX-1:0]         rate,
  input  logic signed [WIDTH_IN-1:0]  in,
  input  logic                        strobe_in,
  output logic signed [WIDTH_OUT-1:0] out,
  output logic                        strobe_out
);
  logic signed [WIDTH_OUT-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic [LOG2_MAX-1:0] cnt_q, cnt_d, eff_rate_q, eff_rate_d, rate_now;
  logic strobe_out_q, strobe_out_d, dump;
  // the period's rate is frozen on its first sample, so that sample already uses the new value
  always_comb begin
    rate_now = (cnt_q == '0) ? ((rate == '0) ? LOG2_MAX'(1) : rate) : eff_rate_q;
    sum = acc_q + {{LOG2_MAX{in[WIDTH_IN-1]}}, in};
    dump = strobe_in && enable && (cnt_q == rate_now - LOG2_MAX'(1));
    acc_d = acc_q;
    cnt_d = cnt_q;
    eff_rate_d = eff_rate_q;
    out_d = dump ? sum : out_q;
    strobe_out_d = dump;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (strobe_in) begin
      eff_rate_d = rate_now;
      acc_d = dump ? '0 : sum;
      cnt_d = dump ? '0 : cnt_q + LOG2_MAX'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      eff_rate_q <= LOG2_MAX'(1);
      out_q <= '0;
      strobe_out_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      eff_rate_q <= eff_rate_d;
      out_q <= out_d;
      strobe_out_q <= strobe_out_d;
    end
  end
  assign out = out_q;
  assign strobe_out = strobe_out_q;
endmodule

// File: doc/integrate_dump.md
INTEGRATE_DUMP -- requirements
Module: integrate_dump

Interface
REQ-001 The block SHALL have parameter WIDTH_IN, default 16, meaning signed input sample width.
REQ-002 The block SHALL have parameter LOG2_MAX, default 8, meaning the rate port width; maximum decimation is 2^LOG2_MAX-1.
REQ-003 The block SHALL have derived localparam WIDTH_OUT = WIDTH_IN+LOG2_MAX, meaning the full-precision output width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1, run enable; low clears the accumulation state.
REQ-007 The block SHALL have port rate, input, LOG2_MAX, samples per dump; 0 is treated as 1.
REQ-008 The block SHALL have port in, input, WIDTH_IN, signed two's-complement sample.
REQ-009 The block SHALL have port strobe_in, input, 1, marking in as valid this cycle.
REQ-010 The block SHALL have port out, output, WIDTH_OUT, signed sum of the last completed period; it feeds round_sd.in directly.
REQ-011 The block SHALL have port strobe_out, output, 1, a one-cycle pulse marking a new out value; it feeds round_sd.strobe_in.

Function
REQ-012 The block SHALL latch rate into an internal eff_rate register at the first accepted strobe_in of each period (cnt==0), so a period always uses one rate.
REQ-013 The block SHALL hold state as an accumulator acc (WIDTH_OUT, signed), a counter cnt (LOG2_MAX bits) and eff_rate.
REQ-014 On strobe_in with enable high and cnt != eff_rate-1, the block SHALL update acc <= acc + sign-extended in and cnt <= cnt+1.
REQ-015 On strobe_in with enable high and cnt == eff_rate-1 (the dump), the block SHALL load out <= acc + sign-extended in, assert strobe_out on the next cycle only, and clear acc and cnt to 0.
REQ-016 Latency SHALL be one clock from the final strobe_in of a period to strobe_out high, with out valid in that same cycle.
REQ-017 For eff_rate == 1, every strobe_in SHALL be a dump: out = sign-extended in, one cycle later.
REQ-018 Cycles without strobe_in SHALL leave acc, cnt and out unchanged, with strobe_out low.
REQ-019 out SHALL hold its value between dumps.
REQ-020 Arithmetic SHALL be full precision with no saturation; the worst case (2^LOG2_MAX-1) x (-2^(WIDTH_IN-1)) fits WIDTH_OUT by construction.
REQ-021 enable low SHALL synchronously clear acc and cnt, force strobe_out to 0 and hold out; the first strobe_in after enable rises starts a fresh period.
REQ-022 A rate change mid-period SHALL take effect at the start of the next period.

Reset
REQ-023 Reset SHALL asynchronously drive acc, cnt, out and strobe_out to 0 and eff_rate to 1.
REQ-024 Reset asserted mid-period SHALL discard the partial sum; after release, the first dump SHALL occur after a full eff_rate fresh samples.

Structure
REQ-025 The LOG2_MAX default and any rate-encoding constants SHALL live in the shared sdr_lib constants header; no typedefs are needed.
REQ-026 The block SHALL be a single module with no sub-modules; a single registered adder serves both the accumulate and dump paths.

Verification (WIDTH_IN=8, LOG2_MAX=3, round_sd WIDTH_IN=11 downstream)
REQ-027 Bench: rate=4, in=5 with strobe_in every cycle -> strobe_out every 4th cycle, one cycle after the 4th strobe, out=20.
REQ-028 Bench: rate=7, in=-128 with strobe_in on alternate cycles -> out=-896, strobe_out spaced 14 cycles apart, no wrap.
REQ-029 Bench: rate=0 and rate=1, in ramping 0..255 -> out equals sign-extended in delayed one cycle, strobe_out on every strobe.
REQ-030 Bench: rate changed 4->2 after the 2nd sample of a period -> that period dumps after 4 samples, later periods after 2.
REQ-031 Bench: reset, then enable dropped after 3 of 4 samples (in=10) -> no strobe_out for that period; after re-enable, 4 samples give out=40, not 70.
REQ-032 Bench: chained into round_sd (WIDTH_OUT=5), ramp as in REQ-029 -> round_sd output mean tracks out/64 within 1 LSB over 64 dumps.
